// File: rtl/cenn_pixel_out.sv
// Converts the signed fixed-point CeNN state stream into tagged 8-bit grayscale pixels:
// clamp/offset stage, rescale stage, then a show-ahead FIFO behind a ready/valid handshake.
module cenn_pixel_out #(
    parameter int width          = 15,
    parameter int bit_fractional = 9,
    parameter int length_column  = 1024,
    parameter int length_row     = 768,
    parameter int fifo_depth     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [width-1:0] cenn_in,
    output logic             in_ready,
    output logic [7:0]       pixel_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             sof_out,
    output logic             eol_out,
    output logic             overflow
);

    localparam int SW = bit_fractional + 2;
    localparam int XW = bit_fractional + 10;
    localparam int CW = (length_column > 1) ? $clog2(length_column) : 1;
    localparam int RW = (length_row > 1) ? $clog2(length_row) : 1;
    localparam int PW = $clog2(fifo_depth);
    localparam int NW = $clog2(fifo_depth + 1);
    localparam int OW = $clog2(fifo_depth + 3);
    localparam logic signed [width-1:0] POS_ONE = width'(2 ** bit_fractional);
    localparam logic signed [width-1:0] NEG_ONE = -POS_ONE;

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic [7:0] pixel;
    } entry_t;

    logic                    s1_valid_q, s1_valid_d;
    logic [SW-1:0]           s1_s_q, s1_s_d;
    logic                    s1_sof_q, s1_sof_d;
    logic                    s1_eol_q, s1_eol_d;
    logic                    s2_valid_q, s2_valid_d;
    entry_t                  s2_entry_q, s2_entry_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d;
    entry_t                  mem_q [fifo_depth];
    entry_t                  mem_d [fifo_depth];

    logic signed [width-1:0] cenn_s;
    logic signed [width-1:0] yc;
    logic [OW-1:0]           occupancy;
    logic                    accept;
    logic                    push;
    logic                    pop;
    entry_t                  head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(fifo_depth - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign cenn_s = cenn_in;

    always_comb begin
        // Everything in flight counts against the FIFO, so a stalled sink can never overrun it.
        occupancy = OW'(count_q) + OW'(s1_valid_q) + OW'(s2_valid_q);
        in_ready  = occupancy < OW'(fifo_depth);
        accept    = valid_in && in_ready;
        push      = s2_valid_q;
        pop       = (count_q != '0) && ready_in;

        if (cenn_s > POS_ONE)      yc = POS_ONE;
        else if (cenn_s < NEG_ONE) yc = NEG_ONE;
        else                       yc = cenn_s;

        s1_valid_d = accept;
        s1_s_d     = SW'(yc + POS_ONE);
        s1_sof_d   = (row_q == '0) && (col_q == '0);
        s1_eol_d   = (col_q == CW'(length_column - 1));

        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == CW'(length_column - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(length_row - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        s2_valid_d       = s1_valid_q;
        s2_entry_d.pixel = 8'((XW'(s1_s_q) * XW'(255) + XW'(2 ** bit_fractional)) >> (bit_fractional + 1));
        s2_entry_d.sof   = s1_sof_q;
        s2_entry_d.eol   = s1_eol_q;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = s2_entry_q;
        wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_next(rd_ptr_q) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | (valid_in & ~in_ready);

        head      = mem_q[rd_ptr_q];
        valid_out = (count_q != '0);
        pixel_out = valid_out ? head.pixel : 8'd0;
        sof_out   = valid_out && head.sof;
        eol_out   = valid_out && head.eol;
        overflow  = overflow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_s_q     <= '0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_entry_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_s_q     <= s1_s_d;
            s1_sof_q   <= s1_sof_d;
            s1_eol_q   <= s1_eol_d;
            s2_valid_q <= s2_valid_d;
            s2_entry_q <= s2_entry_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage has no reset; stale entries are never visible because outputs are gated by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_cenn_pixel_out.sv
// Self-checking bench for cenn_pixel_out: a queue-based model predicts in_ready, valid_out,
// pixel values and frame tags from accepted samples; scenario tasks add directed checks.
module tb_cenn_pixel_out;

    localparam int W     = 15;
    localparam int BF    = 9;
    localparam int LC    = 4;
    localparam int LR    = 2;
    localparam int DEPTH = 4;
    localparam int ONE   = 2 ** BF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_in = 1'b0;
    logic [W-1:0] cenn_in = '0;
    logic         in_ready;
    logic [7:0]   pixel_out;
    logic         valid_out;
    logic         sof_out;
    logic         eol_out;
    logic         overflow;

    always #5 clk = ~clk;

    cenn_pixel_out #(
        .width(W), .bit_fractional(BF), .length_column(LC), .length_row(LR), .fifo_depth(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .cenn_in(cenn_in), .in_ready(in_ready),
        .pixel_out(pixel_out), .valid_out(valid_out), .ready_in(ready_in), .sof_out(sof_out),
        .eol_out(eol_out), .overflow(overflow)
    );

    typedef struct {
        int pix;
        bit sof;
        bit eol;
        int cyc;
    } rec_t;

    rec_t sb[$];     // accepted, not yet popped: model of everything in flight
    rec_t log_q[$];  // observed pops
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_acc = 0;
    bit   ov_exp = 1'b0;

    function automatic int ref_pixel(input int x);
        int yc;
        yc = x;
        if (yc > ONE)  yc = ONE;
        if (yc < -ONE) yc = -ONE;
        return ((yc + ONE) * 255 + ONE) / (2 * ONE);
    endfunction

    function automatic logic [W-1:0] rand_sample();
        int v;
        case ($urandom % 4)
            0:       return ($urandom % 2) ? W'(16383) : W'(-16384);
            1:       begin v = int'($urandom_range(0, 1200)) - 600; return W'(v); end
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: observe and score at the falling edge, then advance to just after the rising edge.
    task automatic tick();
        bit   exp_rdy;
        bit   exp_v;
        rec_t e;
        @(negedge clk);
        exp_rdy = sb.size() < DEPTH;
        exp_v   = (sb.size() > 0) && (cyc >= sb[0].cyc + 3);
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
        end
        checks++;
        if (valid_out !== exp_v) begin
            errors++;
            $display("FAIL valid_out cyc=%0d got=%b exp=%b", cyc, valid_out, exp_v);
        end
        checks++;
        if (overflow !== ov_exp) begin
            errors++;
            $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, ov_exp);
        end
        if (exp_v) begin
            checks++;
            if (pixel_out !== 8'(sb[0].pix) || sof_out !== sb[0].sof || eol_out !== sb[0].eol) begin
                errors++;
                $display("FAIL head cyc=%0d got pix=%0d sof=%b eol=%b exp pix=%0d sof=%b eol=%b",
                         cyc, pixel_out, sof_out, eol_out, sb[0].pix, sb[0].sof, sb[0].eol);
            end
            if (ready_in) begin
                e.pix = int'(pixel_out);
                e.sof = sof_out;
                e.eol = eol_out;
                e.cyc = cyc;
                log_q.push_back(e);
                void'(sb.pop_front());
            end
        end
        if (valid_in && !exp_rdy) ov_exp = 1'b1;
        if (valid_in && exp_rdy) begin
            e.pix = ref_pixel(int'($signed(cenn_in)));
            e.sof = ((n_acc % LC) == 0) && (((n_acc / LC) % LR) == 0);
            e.eol = (n_acc % LC) == LC - 1;
            e.cyc = cyc;
            sb.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset(input string tag);
        #2 rst_n = 1'b0;
        valid_in = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || pixel_out !== 8'd0 || sof_out !== 1'b0 || eol_out !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs got v=%b pix=%0d sof=%b eol=%b exp all 0", tag, valid_out, pixel_out,
                     sof_out, eol_out);
        end
        checks++;
        if (overflow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s flags got ovf=%b in_ready=%b exp 0/1", tag, overflow, in_ready);
        end
        sb.delete();
        log_q.delete();
        n_acc  = 0;
        ov_exp = 1'b0;
        @(posedge clk);
        cyc++;
        @(posedge clk);
        cyc++;
        #2 rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 40 && log_q.size() < n; i++) tick();
        checks++;
        if (log_q.size() != n) begin
            errors++;
            $display("FAIL drain got=%0d exp=%0d pixels", log_q.size(), n);
        end
    endtask

    task automatic test_mapping();
        int vals[6] = '{-512, 0, 512, 16383, -16384, 256};
        int pix[6]  = '{0, 128, 255, 255, 0, 191};
        test_reset("reset_before_mapping");
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1;
            cenn_in  = W'(vals[i]);
            tick();
            valid_in = 1'b0;
            tick();
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL latency_early sample=%0d got valid=%b exp 0", i, valid_out);
            end
            tick();
            checks++;
            if (valid_out !== 1'b1 || pixel_out !== 8'(pix[i])) begin
                errors++;
                $display("FAIL mapping in=%0d got valid=%b pix=%0d exp 1/%0d", vals[i], valid_out, pixel_out,
                         pix[i]);
            end
            tick();
        end
    endtask

    task automatic test_tagging();
        test_reset("reset_before_tagging");
        ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1;
            cenn_in  = rand_sample();
            tick();
        end
        valid_in = 1'b0;
        drain(10);
        for (int i = 0; i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].sof != (i == 0 || i == 8) || log_q[i].eol != (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL tags sample=%0d got sof=%b eol=%b", i, log_q[i].sof, log_q[i].eol);
            end
        end
        checks++;
        if (log_q.size() == 10 && log_q[9].cyc != log_q[0].cyc + 9) begin
            errors++;
            $display("FAIL throughput got span=%0d exp=9", log_q[9].cyc - log_q[0].cyc);
        end
    endtask

    task automatic test_backpressure();
        int acc_vals[$];
        int accepts = 0;
        int fall_at = -1;
        test_reset("reset_before_backpressure");
        ready_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            cenn_in  = rand_sample();
            if (in_ready) begin
                accepts++;
                acc_vals.push_back(int'($signed(cenn_in)));
            end else if (fall_at < 0) begin
                fall_at = accepts;
            end
            tick();
        end
        valid_in = 1'b0;
        checks++;
        if (fall_at != DEPTH || accepts != DEPTH) begin
            errors++;
            $display("FAIL bp_accepts got fall_at=%0d accepts=%0d exp %0d", fall_at, accepts, DEPTH);
        end
        checks++;
        if (valid_out !== 1'b1 || pixel_out !== 8'(ref_pixel(acc_vals[0]))) begin
            errors++;
            $display("FAIL bp_hold got valid=%b pix=%0d exp 1/%0d", valid_out, pixel_out, ref_pixel(acc_vals[0]));
        end
        ready_in = 1'b1;
        drain(DEPTH);
        for (int i = 0; i < log_q.size() && i < acc_vals.size(); i++) begin
            checks++;
            if (log_q[i].pix != ref_pixel(acc_vals[i]) || log_q[i].cyc != log_q[0].cyc + i) begin
                errors++;
                $display("FAIL bp_drain idx=%0d got pix=%0d at +%0d exp pix=%0d at +%0d", i, log_q[i].pix,
                         log_q[i].cyc - log_q[0].cyc, ref_pixel(acc_vals[i]), i);
            end
        end
    endtask

    task automatic test_drop();
        int accepts = 0;
        test_reset("reset_before_drop");
        ready_in = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cenn_in = rand_sample();
            tick();
        end
        valid_in = 1'b0;
        checks++;
        if (overflow !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_pre got ovf=%b in_ready=%b exp 0/0", overflow, in_ready);
        end
        valid_in = 1'b1;
        cenn_in  = W'(999);
        tick();
        valid_in = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_flag got ovf=%b exp 1", overflow);
        end
        ready_in = 1'b1;
        for (int i = 0; i < 40 && accepts < 4; i++) begin
            valid_in = in_ready;
            cenn_in  = rand_sample();
            if (in_ready) accepts++;
            tick();
        end
        valid_in = 1'b0;
        drain(8);
        if (log_q.size() == 8) begin
            checks++;
            if (!log_q[3].eol || log_q[4].eol || !log_q[7].eol) begin
                errors++;
                $display("FAIL drop_col got eol3=%b eol4=%b eol7=%b exp 1/0/1", log_q[3].eol, log_q[4].eol,
                         log_q[7].eol);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_sticky got ovf=%b exp 1", overflow);
        end
    endtask

    task automatic test_reset_midstream();
        test_reset("reset_before_midstream");
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1;
            cenn_in  = rand_sample();
            tick();
        end
        test_reset("reset_midstream");
        valid_in = 1'b1;
        cenn_in  = W'(0);
        tick();
        valid_in = 1'b0;
        drain(1);
        checks++;
        if (log_q.size() != 1 || !log_q[0].sof || log_q[0].pix != 128) begin
            errors++;
            $display("FAIL post_reset_sof got n=%0d exp first pixel sof=1 pix=128", log_q.size());
        end
    endtask

    task automatic test_random();
        test_reset("reset_before_random");
        for (int i = 0; i < 1000; i++) begin
            ready_in = ($urandom % 3) != 0;
            valid_in = ($urandom % 4) != 0;
            cenn_in  = rand_sample();
            tick();
            if (sb.size() > DEPTH) begin
                checks++;
                errors++;
                $display("FAIL occupancy cyc=%0d got=%0d exp<=%0d", cyc, sb.size(), DEPTH);
            end
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain got=%0d left exp 0", sb.size());
        end
    endtask

    initial begin
        test_reset("reset_initial");
        test_mapping();
        test_tagging();
        test_backpressure();
        test_drop();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
